// File: rtl/ecg_playback_ctrl.sv
// ecg_playback_ctrl
// Plays the stored ECG record out of the sample BRAM into the IIR filter.
// It issues paced BRAM reads, hides the BRAM read latency, and presents each
// sample with a one-cycle sample_valid strobe that drives the filter
// clk_enable. It supports single-shot and loop playback, a stop command and a
// pass counter.
//
// Optional build macro: IIR_FLUSH_EN
//   When defined, each playback ends with FLUSH_LEN zero samples at the
//   latched rate so that the filter state decays before the next run.
//   When undefined, the FLUSH state does not exist.

module ecg_playback_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 24,
    parameter int DEPTH     = 2500,
    parameter int DIV_W     = 16,
    parameter int BRAM_LAT  = 1,
    parameter int FLUSH_LEN = 64
) (
    input  logic                     clk_out1_wire,
    input  logic                     system_reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_mode,
    input  logic [DIV_W-1:0]         rate_div,
    output logic                     bram_en,
    output logic [ADDR_W-1:0]        bram_addr,
    input  logic signed [DATA_W-1:0] bram_dout,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              frame_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef IIR_FLUSH_EN
    localparam int                 FLUSH_CW   = $clog2(FLUSH_LEN) + 1;
    localparam logic [FLUSH_CW-1:0] FLUSH_LAST = FLUSH_CW'(FLUSH_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;
`endif

    genvar gi;

    // Only one- and two-cycle BRAM read latencies are supported.
    if (BRAM_LAT < 1 || BRAM_LAT > 2 || FLUSH_LEN < 1) begin : g_bad_param
        $error("ecg_playback_ctrl: BRAM_LAT must be 1 or 2 and FLUSH_LEN >= 1");
    end

    state_t                     state_reg, state_next;
    logic [ADDR_W-1:0]          addr_reg, addr_next;
    logic [DIV_W-1:0]           div_cnt_reg, div_next;
    logic [DIV_W-1:0]           rate_m1_reg, rate_m1_next;
    logic                       loop_reg, loop_next;
    logic [15:0]                frame_cnt_reg, frame_next;
    logic [BRAM_LAT-1:0]        vld_pipe_reg, pipe_next;
    logic                       sample_valid_reg;
    logic signed [DATA_W-1:0]   sample_out_reg;
    logic                       issue;
    logic                       flush_emit;
    logic                       pipe_out;
`ifdef IIR_FLUSH_EN
    logic [FLUSH_CW-1:0]        flush_cnt_reg, flush_next;
`endif

    // Read-tracking shift register: stage 0 takes this cycle's read, each
    // further stage is one more cycle of BRAM latency.
    assign pipe_next[0] = issue;
    for (gi = 1; gi < BRAM_LAT; gi++) begin : g_vld_pipe
        assign pipe_next[gi] = vld_pipe_reg[gi-1];
    end
    assign pipe_out = vld_pipe_reg[BRAM_LAT-1];

    // State register.
    always_ff @(posedge clk_out1_wire or posedge system_reset) begin
        if (system_reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, read issue and control-register update logic.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        div_next     = div_cnt_reg;
        rate_m1_next = rate_m1_reg;
        loop_next    = loop_reg;
        frame_next   = frame_cnt_reg;
        issue        = 1'b0;
        flush_emit   = 1'b0;
`ifdef IIR_FLUSH_EN
        flush_next   = flush_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // A simultaneous stop cancels the start.
                if (start && !stop) begin
                    state_next   = S_RUN;
                    loop_next    = loop_mode;
                    rate_m1_next = (rate_div == '0) ? '0 : rate_div - DIV_W'(1);
                    div_next     = '0;      // first read on the next cycle
                    addr_next    = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // Partial pass: no read this cycle, no frame increment.
                    state_next = S_DRAIN;
                end else if (div_cnt_reg == '0) begin
                    issue    = 1'b1;
                    div_next = rate_m1_reg;
                    if (addr_reg == LAST_ADDR) begin
                        frame_next = frame_cnt_reg + 16'd1;
                        addr_next  = '0;
                        if (!loop_reg) begin
                            state_next = S_DRAIN;
                        end
                    end else begin
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                end else begin
                    div_next = div_cnt_reg - DIV_W'(1);
                end
            end
            S_DRAIN: begin
                // No reads remain in the BRAM pipeline once it is empty;
                // the last one is already in the output register.
                if (vld_pipe_reg == '0) begin
`ifdef IIR_FLUSH_EN
                    state_next = S_FLUSH;
                    div_next   = rate_m1_reg;
                    flush_next = '0;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef IIR_FLUSH_EN
            S_FLUSH: begin
                // Zero samples at the playback rate; start/stop are ignored.
                if (div_cnt_reg == '0) begin
                    flush_emit = 1'b1;
                    div_next   = rate_m1_reg;
                    if (flush_cnt_reg == FLUSH_LAST) begin
                        state_next = S_DONE;
                    end else begin
                        flush_next = flush_cnt_reg + FLUSH_CW'(1);
                    end
                end else begin
                    div_next = div_cnt_reg - DIV_W'(1);
                end
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control registers: address, divider, latched settings, pass counter.
    always_ff @(posedge clk_out1_wire or posedge system_reset) begin
        if (system_reset) begin
            addr_reg      <= '0;
            div_cnt_reg   <= '0;
            rate_m1_reg   <= '0;
            loop_reg      <= 1'b0;
            frame_cnt_reg <= '0;
`ifdef IIR_FLUSH_EN
            flush_cnt_reg <= '0;
`endif
        end else begin
            addr_reg      <= addr_next;
            div_cnt_reg   <= div_next;
            rate_m1_reg   <= rate_m1_next;
            loop_reg      <= loop_next;
            frame_cnt_reg <= frame_next;
`ifdef IIR_FLUSH_EN
            flush_cnt_reg <= flush_next;
`endif
        end
    end

    // Latency compensation and output register; reset drops in-flight reads.
    always_ff @(posedge clk_out1_wire or posedge system_reset) begin
        if (system_reset) begin
            vld_pipe_reg     <= '0;
            sample_valid_reg <= 1'b0;
            sample_out_reg   <= '0;
        end else begin
            vld_pipe_reg     <= pipe_next;
            sample_valid_reg <= pipe_out | flush_emit;
            if (pipe_out) begin
                sample_out_reg <= bram_dout;
            end else if (flush_emit) begin
                sample_out_reg <= '0;
            end
        end
    end

    assign bram_en      = issue;
    assign bram_addr    = addr_reg;
    assign sample_out   = sample_out_reg;
    assign sample_valid = sample_valid_reg;
    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);
    assign frame_count  = frame_cnt_reg;

endmodule

// File: tb/tb_ecg_playback_ctrl.sv
// Testbench for ecg_playback_ctrl: BRAM model holding data = address,
// expected-sample scoreboard, directed playback scenarios.
module tb_ecg_playback_ctrl;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 2500;
    localparam int DIV_W  = 16;
    localparam int LAT    = 2;
`ifdef IIR_FLUSH_EN
    localparam int FL = 64;
`else
    localparam int FL = 0;
`endif

    logic                     clk_out1_wire = 1'b0;
    logic                     system_reset;
    logic                     start, stop, loop_mode;
    logic [DIV_W-1:0]         rate_div;
    logic                     bram_en;
    logic [ADDR_W-1:0]        bram_addr;
    logic signed [DATA_W-1:0] bram_dout;
    logic signed [DATA_W-1:0] sample_out;
    logic                     sample_valid, busy, done;
    logic [15:0]              frame_count;

    ecg_playback_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W),
        .BRAM_LAT(LAT), .FLUSH_LEN(64)
    ) dut (
        .clk_out1_wire(clk_out1_wire), .system_reset(system_reset),
        .start(start), .stop(stop), .loop_mode(loop_mode), .rate_div(rate_div),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .done(done), .frame_count(frame_count)
    );

    always #5 clk_out1_wire = ~clk_out1_wire;

    // BRAM model: content equals address, read latency LAT.
    logic [DATA_W-1:0] rd1 = '0, rd2 = '0;
    always @(posedge clk_out1_wire) begin
        if (bram_en) rd1 <= DATA_W'(bram_addr);
        rd2 <= rd1;
    end
    assign bram_dout = (LAT == 1) ? rd1 : rd2;

    typedef struct {
        logic [DATA_W-1:0] val;
        bit                gap_chk;
    } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0;
    int cyc = 0, rd_cnt = 0, vld_cnt = 0, done_cnt = 0;
    int first_en_cyc = 0, first_vld_cyc = 0, last_vld_cyc = 0, exp_gap = 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: sample outputs mid-cycle, pop scoreboard on each strobe.
    always @(negedge clk_out1_wire) begin
        exp_t e;
        cyc++;
        if (bram_en) begin
            if (rd_cnt == 0) begin
                first_en_cyc = cyc;
                check("first_read_addr", 64'(bram_addr), 64'd0);
            end
            rd_cnt++;
        end
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sample_value", 64'(sample_out), 64'(e.val));
                if (vld_cnt == 0) first_vld_cyc = cyc;
                if (e.gap_chk) check("sample_gap", 64'(cyc - last_vld_cyc), 64'(exp_gap));
                last_vld_cyc = cyc;
                vld_cnt++;
            end
        end
        if (done) done_cnt++;
    end

    task automatic clear_stats();
        rd_cnt = 0; vld_cnt = 0; done_cnt = 0;
        exp_q.delete();
    endtask

    // Expected stream: n reads from address 0 (wrapping), then flush zeros.
    task automatic push_run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.val = DATA_W'(i % DEPTH);
            e.gap_chk = (i != 0);
            exp_q.push_back(e);
        end
        for (int i = 0; i < FL; i++) begin
            e.val = '0;
            e.gap_chk = (i != 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        system_reset = 1'b1;
        repeat (2) @(posedge clk_out1_wire);
        #1 system_reset = 1'b0;
    endtask

    // Start pulse; settings are then scrambled to show they were latched.
    task automatic pulse_start(input logic lm, input logic [DIV_W-1:0] rd);
        @(posedge clk_out1_wire);
        #1 loop_mode = lm; rate_div = rd; start = 1'b1;
        @(posedge clk_out1_wire);
        #1 start = 1'b0; rate_div = 16'd7; loop_mode = ~lm;
    endtask

    task automatic pulse_stop();
        #1 stop = 1'b1;
        @(posedge clk_out1_wire);
        #1 stop = 1'b0;
    endtask

    // Bounded wait for done; returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk_out1_wire);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_end(input string tag, input int nreads, input logic [15:0] frames);
        check({tag, "_busy_with_done"}, 64'(busy), 64'd1);
        @(negedge clk_out1_wire);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_done_width"}, 64'(done), 64'd0);
        check({tag, "_reads"}, 64'(rd_cnt), 64'(nreads));
        check({tag, "_valids"}, 64'(vld_cnt), 64'(nreads + FL));
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_frames"}, 64'(frame_count), 64'(frames));
    endtask

    initial begin
        bit saw_busy;
        start = 1'b0; stop = 1'b0; loop_mode = 1'b0; rate_div = '0;
        system_reset = 1'b1;
        #2;
        // Reset values
        check("rst_bram_en", 64'(bram_en), 64'd0);
        check("rst_bram_addr", 64'(bram_addr), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_sample", 64'(sample_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_frames", 64'(frame_count), 64'd0);
        do_reset();

        // 1: single shot, rate 4
        clear_stats(); exp_gap = 4; push_run(DEPTH);
        pulse_start(1'b0, 16'd4);
        wait_done("t1", DEPTH * 4 + FL * 4 + 200);
        check("t1_first_latency", 64'(first_vld_cyc - first_en_cyc), 64'(LAT + 1));
        check_end("t1", DEPTH, 16'd1);
        $display("txn t1 single-shot rate4: reads=%0d valids=%0d frames=%0d", rd_cnt, vld_cnt, frame_count);

        // 2: loop mode, rate 1, 3*DEPTH+10 reads then stop
        do_reset();
        clear_stats(); exp_gap = 1; push_run(3 * DEPTH + 10);
        pulse_start(1'b1, 16'd1);
        repeat (3 * DEPTH + 10) @(posedge clk_out1_wire);
        pulse_stop();
        wait_done("t2", FL * 2 + 50);
        check_end("t2", 3 * DEPTH + 10, 16'd3);
        $display("txn t2 loop rate1: reads=%0d valids=%0d frames=%0d", rd_cnt, vld_cnt, frame_count);

        // 3: stop after 100th read, rate_div=0 treated as 1
        clear_stats(); exp_gap = 1; push_run(100);
        pulse_start(1'b0, 16'd0);
        repeat (100) @(posedge clk_out1_wire);
        pulse_stop();
        wait_done("t3", FL * 2 + 50);
        check_end("t3", 100, 16'd3);
        $display("txn t3 stop@100: reads=%0d valids=%0d frames=%0d", rd_cnt, vld_cnt, frame_count);

        // 4: start and stop together in IDLE
        clear_stats(); saw_busy = 1'b0;
        @(posedge clk_out1_wire);
        #1 start = 1'b1; stop = 1'b1; rate_div = 16'd1;
        @(posedge clk_out1_wire);
        #1 start = 1'b0; stop = 1'b0;
        repeat (20) begin
            @(negedge clk_out1_wire);
            saw_busy |= busy;
        end
        check("t4_busy", 64'(saw_busy), 64'd0);
        check("t4_reads", 64'(rd_cnt), 64'd0);
        check("t4_done", 64'(done_cnt), 64'd0);
        $display("txn t4 start+stop idle: reads=%0d busy_seen=%0d", rd_cnt, saw_busy);

        // 5: asynchronous reset mid-run with reads in flight, then restart
        clear_stats(); exp_gap = 1; push_run(DEPTH);
        pulse_start(1'b0, 16'd1);
        repeat (50) @(posedge clk_out1_wire);
        #3 system_reset = 1'b1;
        exp_q.delete();
        @(negedge clk_out1_wire);
        check("t5_rst_bram_en", 64'(bram_en), 64'd0);
        check("t5_rst_addr", 64'(bram_addr), 64'd0);
        check("t5_rst_valid", 64'(sample_valid), 64'd0);
        check("t5_rst_sample", 64'(sample_out), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_frames", 64'(frame_count), 64'd0);
        @(posedge clk_out1_wire);
        #1 system_reset = 1'b0;
        vld_cnt = 0;
        repeat (10) @(negedge clk_out1_wire);
        check("t5_no_valid_after_rst", 64'(vld_cnt), 64'd0);
        $display("txn t5 reset mid-run: valids_after_reset=%0d", vld_cnt);
        clear_stats(); push_run(DEPTH);
        pulse_start(1'b0, 16'd1);
        wait_done("t5", DEPTH + FL + 100);
        check_end("t5", DEPTH, 16'd1);
        $display("txn t5 restart: reads=%0d valids=%0d frames=%0d", rd_cnt, vld_cnt, frame_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecg_playback_ctrl.md
Name: ecg_playback_ctrl

Overview:
- Sequences playback of the stored ECG record from the sample BRAM into the IIR filter.
- Generates the BRAM enable and address, and paces reads to a programmable sample rate derived from clk_out1_wire.
- Compensates BRAM read latency and emits each sample with a one-cycle valid strobe, which drives the filter's clk_enable.
- Supports single-shot and loop playback, start/stop control and a frame counter.

Parameters:
- ADDR_W, 12, BRAM address width.
- DATA_W, 24, sample width (signed).
- DEPTH, 2500, number of valid samples; last address is DEPTH-1.
- DIV_W, 16, width of the rate divider.
- BRAM_LAT, 1, BRAM read latency in cycles; legal values are 1 or 2.
- FLUSH_LEN, 64, number of zero samples emitted when IIR_FLUSH_EN is defined.

Ports:
- clk_out1_wire  in  1  system clock from the clocking wizard.
- system_reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins playback from address 0.
- stop  in  1  single-cycle pulse; aborts playback.
- loop_mode  in  1  1 = wrap continuously, 0 = single shot; sampled on an accepted start.
- rate_div  in  DIV_W  clk_out1_wire cycles per sample; sampled on an accepted start; 0 is treated as 1.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  DATA_W  BRAM read data.
- sample_out  out  DATA_W  registered sample to the filter.
- sample_valid  out  1  one-cycle strobe; connects to the filter clk_enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when playback finishes, whether normally or by stop.
- frame_count  out  16  completed passes through the record; wraps at 65535.

Behaviour:
- Reset values: all outputs 0; state IDLE; divider counter 0; address register 0.
- States:
  - IDLE: start -> RUN. Latch loop_mode and rate_div (0 -> 1). Clear the address to 0. Load the divider so the first read issues on the next cycle.
  - RUN: divider counts down from rate_div-1. When it reaches 0, issue a read: bram_en=1 for one cycle with bram_addr = current address. The address then increments and the divider reloads.
  - On a read at address DEPTH-1:
    - frame_count increments.
    - loop_mode=1: address wraps to 0; stay in RUN with no gap, so pacing is continuous across the wrap.
    - loop_mode=0: go to DRAIN.
  - DRAIN: issue no further reads. Wait until every in-flight read (at most BRAM_LAT cycles old) has produced its sample_valid, then go to FLUSH (if enabled) or DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Data path:
  - A shift register of depth BRAM_LAT tracks issued reads.
  - sample_valid asserts exactly BRAM_LAT+1 cycles after the bram_en cycle: BRAM_LAT cycles of BRAM latency plus one output register.
  - sample_out <= bram_dout on that cycle. sample_out holds its value between strobes.
- stop in RUN: no further reads; go to DRAIN. In-flight samples are still delivered. frame_count is not incremented for a partial pass.
- stop in IDLE or DONE: ignored.
- start while busy: ignored.
- start and stop in the same cycle: stop wins; from IDLE both are ignored.
- rate_div=1: one read every cycle, giving a continuous sample_valid stream.
- Changes to rate_div or loop_mode while busy have no effect until the next start.
- system_reset mid-operation: immediate return to reset values. In-flight reads are discarded and no sample_valid follows.

Optional Feature:
- Macro: IIR_FLUSH_EN.
- Defined:
  - After DRAIN in single-shot mode or after stop, enter FLUSH.
  - FLUSH emits FLUSH_LEN samples of value 0 at the latched rate (one sample_valid per rate_div cycles), with bram_en held 0, then goes to DONE.
  - Purpose: the filter's internal state decays to zero before the next playback.
  - stop during FLUSH is ignored; start during FLUSH is ignored.
- Not defined: FLUSH does not exist; DRAIN goes directly to DONE.

Test Plan:
1. Single shot, DEPTH=2500, rate_div=4, BRAM preloaded with data = address -> exactly 2500 sample_valid pulses, 4 cycles apart, values 0..2499 in order; first valid occurs BRAM_LAT+1 cycles after the first bram_en; done pulses once; frame_count=1; busy falls with done.
2. loop_mode=1, rate_div=1, run 3*2500+10 cycles -> contiguous valids; value 2499 is followed immediately by 0; frame_count=3.
3. stop after the 100th read with rate_div=1, BRAM_LAT=2 -> the in-flight reads are still delivered, bringing the total sample_valid count to 100; then done, busy=0, frame_count unchanged.
4. start and stop asserted together while in IDLE -> nothing happens: bram_en stays 0, busy stays 0.
5. system_reset asserted mid-RUN while reads are in flight -> all outputs 0 next cycle; no sample_valid after reset; a subsequent start restarts at address 0.
6. IIR_FLUSH_EN defined, single shot, rate_div=2 -> 2500 data samples followed by 64 zero samples, each 2 cycles apart, with bram_en=0 during flush; then done.
